// File: rtl/ascon_perm_iter.sv
`default_nettype none
// ============================================================================
// ascon_perm_iter : iterative Ascon-p[6/8/12] permutation, 1 or 2 rounds/clk
// Revision 1.0
// ============================================================================
module ascon_perm_iter #(
    parameter int UNROLL  = 1,
    parameter int OUT_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  nr,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4,
    output logic        busy
);
    localparam logic [3:0] STEP = (UNROLL == 2) ? 4'd2 : 4'd1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    typedef logic [4:0][63:0] word5_t;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // k runs 12-A .. 11; constant byte is {15-k, k} == {~k, k}
    function automatic word5_t ascon_round(input word5_t s, input logic [3:0] k);
        logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
        word5_t o;
        a0 = s[0];
        a1 = s[1];
        a2 = s[2] ^ {56'd0, ~k, k};
        a3 = s[3];
        a4 = s[4];
        a0 = a0 ^ a4;  a4 = a4 ^ a3;  a2 = a2 ^ a1;
        t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
        a0 = a0 ^ t1;  a1 = a1 ^ t2;  a2 = a2 ^ t3;  a3 = a3 ^ t4;  a4 = a4 ^ t0;
        a1 = a1 ^ a0;  a0 = a0 ^ a4;  a3 = a3 ^ a2;  a2 = ~a2;
        o[0] = a0 ^ rotr(a0, 19) ^ rotr(a0, 28);
        o[1] = a1 ^ rotr(a1, 61) ^ rotr(a1, 39);
        o[2] = a2 ^ rotr(a2, 1)  ^ rotr(a2, 6);
        o[3] = a3 ^ rotr(a3, 10) ^ rotr(a3, 17);
        o[4] = a4 ^ rotr(a4, 7)  ^ rotr(a4, 41);
        return o;
    endfunction

    state_t     state;
    word5_t     st;
    word5_t     next_st;
    logic [3:0] rcnt;
    logic [3:0] total;
    logic [3:0] kbase;
    logic [3:0] kr;
    logic       last;

    assign kr   = kbase + rcnt;
    assign last = ((rcnt + STEP) == total);

    generate
        if (UNROLL == 2) begin : g_unroll2
            assign next_st = ascon_round(ascon_round(st, kr), kr + 4'd1);
        end else begin : g_unroll1
            assign next_st = ascon_round(st, kr);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            rcnt      <= 4'd0;
            total     <= 4'd0;
            kbase     <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st   <= {x4, x3, x2, x1, x0};
                        rcnt <= 4'd0;
                        case (nr)
                            2'b00:   begin total <= 4'd6;  kbase <= 4'd6; end
                            2'b01:   begin total <= 4'd8;  kbase <= 4'd4; end
                            default: begin total <= 4'd12; kbase <= 4'd0; end
                        endcase
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    st   <= next_st;
                    rcnt <= rcnt + STEP;
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            word5_t y_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    y_q <= '0;
                else if (state == RUN && last)
                    y_q <= next_st;
            end
            assign {y4, y3, y2, y1, y0} = y_q;
        end else begin : g_out_state
            assign {y4, y3, y2, y1, y0} = st;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_iter.sv
`default_nettype none
// ============================================================================
// tb_ascon_perm_iter : directed bench, UNROLL=1/OUT_REG=1 and UNROLL=2/OUT_REG=0
// Revision 1.0
// ============================================================================
module tb_ascon_perm_iter;
    typedef logic [4:0][63:0] st_t;

    // Ascon S-box, entry i at bits [5*i +: 5]
    localparam logic [159:0] SBOX_TAB = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  nr = 2'b00;
    logic [63:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0, x4 = '0;
    logic        in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2;
    logic [63:0] a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;
    st_t         ya, yb;
    int          n_vec = 0;
    int          n_err = 0;

    assign ya = {a4, a3, a2, a1, a0};
    assign yb = {b4, b3, b2, b1, b0};

    always #5 clk = ~clk;

    ascon_perm_iter #(.UNROLL(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .nr(nr),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .out_valid(out_valid1), .out_ready(out_ready),
        .y0(a0), .y1(a1), .y2(a2), .y3(a3), .y4(a4), .busy(busy1));

    ascon_perm_iter #(.UNROLL(2), .OUT_REG(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .nr(nr),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .out_valid(out_valid2), .out_ready(out_ready),
        .y0(b0), .y1(b1), .y2(b2), .y3(b3), .y4(b4), .busy(busy2));

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bit-sliced reference: S-box by table lookup on each 5-bit column
    function automatic st_t model_perm(input st_t s, input int rounds);
        st_t w, v;
        int k;
        logic [4:0] col, o;
        w = s;
        for (int j = 0; j < rounds; j++) begin
            k = 12 - rounds + j;
            w[2][7:0] = w[2][7:0] ^ 8'(((15 - k) << 4) | k);
            for (int b = 0; b < 64; b++) begin
                col = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
                o = SBOX_TAB[col*5 +: 5];
                {v[0][b], v[1][b], v[2][b], v[3][b], v[4][b]} = o;
            end
            w[0] = v[0] ^ {v[0][18:0], v[0][63:19]} ^ {v[0][27:0], v[0][63:28]};
            w[1] = v[1] ^ {v[1][60:0], v[1][63:61]} ^ {v[1][38:0], v[1][63:39]};
            w[2] = v[2] ^ {v[2][0],    v[2][63:1]}  ^ {v[2][5:0],  v[2][63:6]};
            w[3] = v[3] ^ {v[3][9:0],  v[3][63:10]} ^ {v[3][16:0], v[3][63:17]};
            w[4] = v[4] ^ {v[4][6:0],  v[4][63:7]}  ^ {v[4][40:0], v[4][63:41]};
        end
        return w;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    // One operation on both DUTs; disturb pokes in_valid/nr/x during RUN,
    // hold keeps out_ready low in DONE while in_valid toggles
    task automatic op(input string tag, input logic [1:0] nrv, input st_t s,
                      input bit disturb, input int hold);
        st_t e;
        int  a, n, lat1, lat2;
        a = (nrv == 2'b00) ? 6 : (nrv == 2'b01) ? 8 : 12;
        e = model_perm(s, a);
        @(negedge clk);
        nr = nrv;
        {x4, x3, x2, x1, x0} = s;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, 320'({busy1, busy2, in_ready1, in_ready2}), 320'(4'b1100));
        n = 1; lat1 = 0; lat2 = 0;
        while ((lat1 == 0 || lat2 == 0) && n < 40) begin
            if (out_valid1 && lat1 == 0) lat1 = n;
            if (out_valid2 && lat2 == 0) lat2 = n;
            if (disturb && n == 2) begin
                in_valid = 1'b1;
                nr = ~nrv;
                {x4, x3, x2, x1, x0} = ~s;
            end else begin
                in_valid = 1'b0;
            end
            if (lat1 == 0 || lat2 == 0) begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_lat1"}, 320'(lat1), 320'(a + 1));
        check({tag, "_lat2"}, 320'(lat2), 320'(a / 2 + 1));
        check({tag, "_y1"}, ya, e);
        check({tag, "_y2"}, yb, e);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            {x4, x3, x2, x1, x0} = rand_state();
            @(negedge clk);
            check({tag, "_hold_y1"}, ya, e);
            check({tag, "_hold_y2"}, yb, e);
            check({tag, "_hold_rdy"}, 320'({in_ready1, in_ready2, out_valid1, out_valid2}),
                  320'(4'b0011));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, 320'({in_ready1, in_ready2, out_valid1, out_valid2, busy1, busy2}),
              320'(6'b110000));
        if (hold > 0) begin
            @(negedge clk);
            check({tag, "_noaccept"}, 320'({in_ready1, in_ready2, busy1, busy2}), 320'(4'b1100));
        end
    endtask

    initial begin
        st_t s, cnt_st;
        int  ov_seen;
        for (int i = 0; i < 5; i++)
            for (int b = 0; b < 8; b++)
                cnt_st[i][63 - 8*b -: 8] = 8'(8*i + b);

        #1 rst = 1'b1;
        #2;
        check("reset_ctl1", 320'({in_ready1, out_valid1, busy1}), 320'(3'b100));
        check("reset_ctl2", 320'({in_ready2, out_valid2, busy2}), 320'(3'b100));
        check("reset_y1", ya, '0);
        check("reset_y2", yb, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op("p12_zero", 2'b10, '0, 1'b0, 0);
        op("p6_cnt", 2'b00, cnt_st, 1'b0, 0);
        op("p8_cnt", 2'b01, cnt_st, 1'b0, 0);
        op("p12_rand", 2'b10, rand_state(), 1'b0, 0);
        s = rand_state();
        op("nr11", 2'b11, s, 1'b0, 0);
        op("run_poke", 2'b00, rand_state(), 1'b1, 0);
        op("done_hold", 2'b01, rand_state(), 1'b0, 5);

        // abort mid-RUN with an asynchronous reset
        @(negedge clk);
        nr = 2'b10;
        {x4, x3, x2, x1, x0} = rand_state();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ctl1", 320'({in_ready1, out_valid1, busy1}), 320'(3'b100));
        check("abort_ctl2", 320'({in_ready2, out_valid2, busy2}), 320'(3'b100));
        check("abort_y1", ya, '0);
        check("abort_y2", yb, '0);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid1 || out_valid2) ov_seen++;
        end
        check("abort_no_ov", 320'(ov_seen), 320'(0));
        op("after_abort", 2'b01, rand_state(), 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
